// File: rtl/mem_pkg.sv
// Shared constants and helpers for the latency-configurable RAM model:
// read-latency bound, stall LFSR definition and stall run limit.
package mem_pkg;

  localparam int         MAX_READ_LATENCY = 8;
  localparam logic [7:0] LFSR_SEED        = 8'hA5;
  // Taps 8,6,5,4 of a left-shifting Fibonacci LFSR map to bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS        = 8'hB8;
  localparam logic [1:0] STALL_LIMIT      = 2'd3;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift pipeline carrying a valid bit alongside a data word;
// rst synchronously empties every stage.
module delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out
);

  logic             valid_q [DEPTH];
  logic [WIDTH-1:0] data_q  [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= valid_in;
      data_q[0]  <= data_in;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_out = valid_q[DEPTH-1];
  assign data_out  = data_q[DEPTH-1];

endmodule

// File: rtl/ram_delayn.sv
// Single-port word RAM with a pipelined read path of configurable latency,
// optional pseudo-random waitrequest stalls and a sticky read/write-collision flag.
module ram_delayn
  import mem_pkg::*;
#(
  parameter int    DATA_WIDTH    = 16,
  parameter int    ADDR_WIDTH    = 12,
  parameter int    READ_LATENCY  = 1,
  parameter int    STALL_MODE    = 0,
  parameter string RAM_INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest,
  output logic                  error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("ram_delayn: READ_LATENCY must lie in 1..8");
  end
  if (STALL_MODE != 0 && STALL_MODE != 1) begin : g_bad_stall_mode
    $error("ram_delayn: STALL_MODE must be 0 or 1");
  end

  // Handshake: a request (read|write) is taken at a rising edge only when
  // waitrequest=0 and rst=0; while waitrequest=1 the master holds address,
  // read, write and writedata unchanged. readdatavalid is a one-cycle pulse
  // per accepted read, in request order, with no back-pressure.
  logic                  req;
  logic                  accept;
  logic                  acc_write;
  logic                  acc_read;
  logic                  collision;
  logic [7:0]            lfsr;
  logic [1:0]            stall_cnt;
  logic                  error_q;
  logic                  pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign req       = read | write;
  assign accept    = req & ~waitrequest & ~rst;
  assign acc_write = accept & write;
  assign collision = accept & read & write;
  // A collided request performs only its write, so it launches no read.
  assign acc_read  = accept & read & ~write;

  // The run limit guarantees forward progress however the LFSR bits fall.
  assign waitrequest = (STALL_MODE == 1) ? (lfsr[0] & req & (stall_cnt < STALL_LIMIT))
                                         : 1'b0;

  always @(posedge clk) begin
    if (acc_write) begin
      mem[address] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= LFSR_SEED;
      stall_cnt <= '0;
      error_q   <= 1'b0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (waitrequest) begin
        stall_cnt <= (stall_cnt == STALL_LIMIT) ? stall_cnt : stall_cnt + 2'd1;
      end else begin
        stall_cnt <= '0;
      end
      if (collision) begin
        error_q <= 1'b1;
      end
    end
  end

  delay_line #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (READ_LATENCY)
  ) u_read_pipe (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (acc_read),
    .data_in   (mem[address]),
    .valid_out (pipe_valid),
    .data_out  (pipe_data)
  );

  // Gating by rst keeps both flags low for the whole reset cycle,
  // including a read that would otherwise complete during it.
  assign readdata      = pipe_data;
  assign readdatavalid = pipe_valid & ~rst;
  assign error         = error_q & ~rst;

endmodule

// File: tb/tb_ram_delayn.sv
// Self-checking bench for ram_delayn: five instances with different parameter
// sets are driven cycle by cycle and compared against a transaction-level model.
module tb_ram_delayn;

  localparam int NI = 5;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 3 : 2;
  endfunction
  function automatic int dw_of(input int g);
    return (g == 4) ? 32 : 16;
  endfunction
  function automatic int aw_of(input int g);
    return (g == 4) ? 6 : 12;
  endfunction
  function automatic bit sm_of(input int g);
    return (g == 3);
  endfunction
  function automatic logic [31:0] amask(input int g);
    return (g == 4) ? 32'h0000_003F : 32'h0000_0FFF;
  endfunction
  function automatic logic [31:0] dmask(input int g);
    return (g == 4) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        read_s  [NI];
  logic        write_s [NI];
  logic [11:0] addr_s  [NI];
  logic [31:0] wdata_s [NI];
  logic [31:0] rdata_w [NI];
  logic        rvalid_w[NI];
  logic        wait_w  [NI];
  logic        err_w   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DW = dw_of(g);
    localparam int AW = aw_of(g);
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          wreq;
    logic          err;
    ram_delayn #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .READ_LATENCY  (lat_of(g)),
      .STALL_MODE    (int'(sm_of(g))),
      .RAM_INIT_FILE ("")
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .address       (addr_s[g][AW-1:0]),
      .write         (write_s[g]),
      .read          (read_s[g]),
      .writedata     (wdata_s[g][DW-1:0]),
      .readdata      (rdata),
      .readdatavalid (rvalid),
      .waitrequest   (wreq),
      .error         (err)
    );
    assign rdata_w[g]  = 32'(rdata);
    assign rvalid_w[g] = rvalid;
    assign wait_w[g]   = wreq;
    assign err_w[g]    = err;
  end

  // reference model and scoreboard
  logic [31:0] mem_m [int];
  logic [31:0] exp_q [NI][$];
  int          due_q [NI][$];
  logic        err_m   [NI];
  int          lfsr_m  [NI];
  int          cnt_m   [NI];
  logic        wait_m  [NI];
  int          run_c   [NI];
  int          max_run [NI];
  int          pulses  [NI];
  int          acc_rd  [NI];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d cyc%0d: observed %h expected %h", tag, g, cyc, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model for the inputs now
  // applied, advance the model across the coming edge, then return at negedge.
  task automatic step();
    logic req, exp_w, exp_v, acc;
    int   key, fb;
    #1;
    for (int g = 0; g < NI; g++) begin
      req   = read_s[g] | write_s[g];
      exp_w = sm_of(g) && lfsr_m[g][0] && req && (cnt_m[g] < 3);
      exp_v = !rst && (due_q[g].size() > 0) && (due_q[g][0] == cyc);
      chk("waitrequest", g, 32'(wait_w[g]), 32'(exp_w));
      chk("readdatavalid", g, 32'(rvalid_w[g]), 32'(exp_v));
      chk("error", g, 32'(err_w[g]), 32'(!rst && err_m[g]));
      if (exp_v) begin
        chk("readdata", g, rdata_w[g], exp_q[g][0]);
        void'(exp_q[g].pop_front());
        void'(due_q[g].pop_front());
      end
      if (rvalid_w[g]) pulses[g]++;
      run_c[g] = wait_w[g] ? run_c[g] + 1 : 0;
      if (run_c[g] > max_run[g]) max_run[g] = run_c[g];
      wait_m[g] = exp_w;
      if (rst) begin
        exp_q[g].delete();
        due_q[g].delete();
        err_m[g]  = 1'b0;
        lfsr_m[g] = 'hA5;
        cnt_m[g]  = 0;
      end else begin
        acc = req && !exp_w;
        key = g * 4096 + int'(32'(addr_s[g]) & amask(g));
        if (acc && write_s[g]) begin
          mem_m[key] = wdata_s[g] & dmask(g);
        end else if (acc) begin
          exp_q[g].push_back(mem_m[key]);
          due_q[g].push_back(cyc + lat_of(g));
          acc_rd[g]++;
        end
        if (acc && read_s[g] && write_s[g]) err_m[g] = 1'b1;
        cnt_m[g]  = exp_w ? cnt_m[g] + 1 : 0;
        fb        = ((lfsr_m[g] >> 7) ^ (lfsr_m[g] >> 5) ^ (lfsr_m[g] >> 4) ^ (lfsr_m[g] >> 3)) & 1;
        lfsr_m[g] = ((lfsr_m[g] << 1) | fb) & 'hFF;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // driver tasks
  task automatic idle(input int g);
    read_s[g]  = 1'b0;
    write_s[g] = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Single request held until accepted (at most a few stalled cycles).
  task automatic req_op(input int g, input bit rd, input bit wr,
                        input logic [11:0] a, input logic [31:0] d);
    int n;
    n = 0;
    read_s[g]  = rd;
    write_s[g] = wr;
    addr_s[g]  = a;
    wdata_s[g] = d;
    do begin
      step();
      n++;
    end while (wait_m[g] && n < 8);
    idle(g);
  endtask

  // Back-to-back reads of consecutive addresses, advancing only when accepted.
  task automatic burst_read(input int g, input logic [11:0] base, input int n);
    int k;
    k = 0;
    read_s[g] = 1'b1;
    addr_s[g] = base;
    for (int i = 0; i < 4 * n && k < n; i++) begin
      step();
      if (!wait_m[g]) begin
        k++;
        addr_s[g] = base + 12'(k);
      end
    end
    idle(g);
  endtask

  // Continuous random traffic over a written address window.
  task automatic traffic(input int g, input logic [11:0] base, input int span,
                         input int n, input bit allow_wr);
    read_s[g]  = 1'b1;
    write_s[g] = 1'b0;
    addr_s[g]  = base + 12'($urandom_range(0, span - 1));
    for (int i = 0; i < n; i++) begin
      step();
      if (!wait_m[g]) begin
        addr_s[g] = base + 12'($urandom_range(0, span - 1));
        if (allow_wr && $urandom_range(0, 3) == 0) begin
          read_s[g]  = 1'b0;
          write_s[g] = 1'b1;
          wdata_s[g] = $urandom;
        end else begin
          read_s[g]  = 1'b1;
          write_s[g] = 1'b0;
        end
      end
    end
    idle(g);
  endtask

  initial begin
    for (int g = 0; g < NI; g++) begin
      read_s[g]  = 1'b0;
      write_s[g] = 1'b0;
      addr_s[g]  = '0;
      wdata_s[g] = '0;
      err_m[g]   = 1'b0;
      lfsr_m[g]  = 'hA5;
      cnt_m[g]   = 0;
      wait_m[g]  = 1'b0;
      run_c[g]   = 0;
      max_run[g] = 0;
      pulses[g]  = 0;
      acc_rd[g]  = 0;
    end
    rst = 1'b1;
    @(negedge clk);
    drain(3);
    rst = 1'b0;
    drain(2);

    // latency 1: write then read on the next cycle
    req_op(0, 1'b0, 1'b1, 12'h010, 32'h1234);
    req_op(0, 1'b1, 1'b0, 12'h010, 32'h0);
    drain(2);
    for (int i = 0; i < 16; i++) req_op(0, 1'b0, 1'b1, 12'h100 + 12'(i), $urandom);
    traffic(0, 12'h100, 16, 40, 1'b1);
    req_op(0, 1'b0, 1'b1, 12'hFFF, 32'hA5C3);
    req_op(0, 1'b1, 1'b0, 12'hFFF, 32'h0);
    drain(2);

    // latency 4: preload 0..7 and read them back-to-back
    for (int i = 0; i < 8; i++) req_op(1, 1'b0, 1'b1, 12'(i), 32'(i));
    burst_read(1, 12'h000, 8);
    drain(6);
    for (int i = 0; i < 8; i++) req_op(1, 1'b0, 1'b1, 12'h200 + 12'(i), $urandom);
    traffic(1, 12'h200, 8, 40, 1'b1);
    drain(6);

    // read and write together: write only, no read result, sticky error
    read_s[0]  = 1'b1;
    write_s[0] = 1'b1;
    addr_s[0]  = 12'h020;
    wdata_s[0] = 32'hBEEF;
    step();
    idle(0);
    drain(4);
    req_op(0, 1'b1, 1'b0, 12'h020, 32'h0);
    drain(3);

    // latency 3: three reads in flight, then a one-cycle reset
    for (int i = 0; i < 3; i++) req_op(2, 1'b0, 1'b1, 12'h030 + 12'(i), $urandom);
    burst_read(2, 12'h030, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drain(8);
    burst_read(2, 12'h030, 3);
    drain(5);

    // stall mode: writes, then read held for 200 cycles, then mixed traffic
    for (int i = 0; i < 8; i++) req_op(3, 1'b0, 1'b1, 12'h040 + 12'(i), $urandom);
    traffic(3, 12'h040, 8, 200, 1'b0);
    traffic(3, 12'h040, 8, 80, 1'b1);
    drain(5);
    chk("max_wait_run_le_3", 3, 32'(max_run[3] <= 3), 32'd1);
    chk("pulses_per_accepted_read", 3, 32'(pulses[3]), 32'(acc_rd[3]));

    // 32-bit data, 6-bit address: top word, plus an address that wraps onto it
    req_op(4, 1'b0, 1'b1, 12'h03F, $urandom | 32'h8000_0001);
    req_op(4, 1'b1, 1'b0, 12'h03F, 32'h0);
    req_op(4, 1'b0, 1'b1, 12'h07F, 32'hDEAD_BEEF);
    req_op(4, 1'b1, 1'b0, 12'h03F, 32'h0);
    drain(4);
    for (int g = 0; g < NI; g++) begin
      chk("all_reads_returned", g, 32'(exp_q[g].size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_delayn.md
RAM_DELAYN -- requirements
Module: ram_delayn

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sets the data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 12, sets the address width; depth is 2**ADDR_WIDTH words.
REQ-003 Parameter READ_LATENCY, default 1, legal range 1..8, sets the read latency in cycles; an out-of-range value SHALL fail elaboration.
REQ-004 Parameter STALL_MODE, default 0: 0 = never stall, 1 = pseudo-random waitrequest stalls.
REQ-005 Parameter RAM_INIT_FILE, default "", names a hex image loaded at time 0; an empty string SHALL leave contents X.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 address  input  ADDR_WIDTH  word address.
REQ-009 write  input  1  write request.
REQ-010 read  input  1  read request.
REQ-011 writedata  input  DATA_WIDTH  write data.
REQ-012 readdata  output  DATA_WIDTH  read data, meaningful only while readdatavalid=1.
REQ-013 readdatavalid  output  1  one-cycle pulse per completed read.
REQ-014 waitrequest  output  1  request not accepted this cycle; master holds its request.
REQ-015 error  output  1  sticky flag set by read and write asserted in the same cycle.

Function
REQ-016 A request SHALL be accepted at a rising edge where (read|write)=1, waitrequest=0 and rst=0.
REQ-017 An accepted write SHALL commit writedata to mem[address] at the acceptance edge.
REQ-018 A read accepted at edge E0 SHALL present readdata=mem[address] with readdatavalid=1 during the cycle following edge E(READ_LATENCY-1), so the master samples it at edge E(READ_LATENCY); with READ_LATENCY=1 the data is sampled at the next edge.
REQ-019 Reads SHALL be fully pipelined: one read accepted per cycle, up to READ_LATENCY in flight, and results returned in request order.
REQ-020 The read value SHALL be taken from the array at the acceptance edge, so a write accepted at any earlier edge is visible to it.
REQ-021 When read=1 and write=1 in the same cycle, only the write SHALL be performed, no readdatavalid SHALL be generated for it, and error SHALL be set to 1.
REQ-022 With STALL_MODE=0, waitrequest SHALL be constant 0.
REQ-023 With STALL_MODE=1, the block SHALL use an 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded 8'hA5 and advancing every cycle.
REQ-024 With STALL_MODE=1, waitrequest SHALL equal lfsr[0] & (read|write), computed combinationally.
REQ-025 With STALL_MODE=1, a saturating counter SHALL force waitrequest=0 after 3 consecutive stalled cycles; the counter clears on any accepted request or on an idle cycle.
REQ-026 Address wrap needs no handling, because every ADDR_WIDTH value addresses a valid word.

Reset
REQ-027 While rst=1: readdatavalid=0, error=0, all in-flight reads discarded, LFSR=8'hA5, stall counter=0, and no request accepted.
REQ-028 Reset SHALL NOT alter memory contents.
REQ-029 A reset asserted mid-read SHALL prevent any readdatavalid pulse for reads accepted before the reset.
REQ-030 readdata is don't-care while readdatavalid=0.

Structure
REQ-031 Package mem_pkg SHALL hold MAX_READ_LATENCY=8, LFSR_SEED=8'hA5, the LFSR tap mask, and STALL_LIMIT=3.
REQ-032 The read pipeline SHALL be a sub-module delay_line (parameters WIDTH and DEPTH; carries the valid bit and data; synchronous clear on rst).

Verification
REQ-033 READ_LATENCY=1, STALL_MODE=0: write 16'h1234 to 12'h010, read 12'h010 on the next cycle -> readdata=16'h1234 with readdatavalid=1 sampled one edge after acceptance.
REQ-034 READ_LATENCY=4: back-to-back reads of 12'h000..12'h007 preloaded with 0..7 -> 8 consecutive readdatavalid pulses with data 0..7 in order, the first sampled 4 edges after the first acceptance.
REQ-035 STALL_MODE=1: hold read=1 for 200 cycles -> no waitrequest run longer than 3 cycles, and exactly one readdatavalid per accepted read.
REQ-036 read=1 and write=1 with address 12'h020 and writedata 16'hBEEF -> mem[12'h020]=16'hBEEF, no readdatavalid, error=1 held until rst.
REQ-037 READ_LATENCY=3: issue 3 reads, then assert rst for 1 cycle -> zero readdatavalid pulses afterwards and memory contents unchanged.
REQ-038 Parameter sweep DATA_WIDTH=32, ADDR_WIDTH=6: write to 6'h3F and read it back -> full 32-bit value returned.
